// File: rtl/alu_result_stage.sv
// ALU result writeback stage: a two-entry skid buffer (main + skid) carrying result/tag/wen,
// plus a flag register updated on accept and a branch-condition evaluator on those flags.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_sign,
  input  logic [TAG_W-1:0]  in_rd,
  input  logic              in_wen,
  input  logic              in_flag_upd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_rd,
  output logic              out_wen,
  output logic              flag_zero,
  output logic              flag_sign,
  input  logic [2:0]        br_cond,
  output logic              br_taken,
  output logic [1:0]        occupancy
);

  logic              r_main_vld;
  logic [DATA_W-1:0] r_main_result;
  logic [TAG_W-1:0]  r_main_rd;
  logic              r_main_wen;
  logic              r_skid_vld;
  logic [DATA_W-1:0] r_skid_result;
  logic [TAG_W-1:0]  r_skid_rd;
  logic              r_skid_wen;
  logic              r_flag_zero;
  logic              r_flag_sign;

  logic w_acc;
  logic w_rel;
  logic w_main_free;

  function automatic logic br_eval(input logic [2:0] cond, input logic z, input logic s);
    case (cond)
      3'd0:    br_eval = 1'b0;
      3'd1:    br_eval = 1'b1;
      3'd2:    br_eval = z;
      3'd3:    br_eval = ~z;
      3'd4:    br_eval = s;
      3'd5:    br_eval = ~s;
      3'd6:    br_eval = z | s;
      default: br_eval = ~z & ~s;
    endcase
  endfunction

  // in_ready depends only on registered skid state, never on out_ready
  assign in_ready    = ~rst & ~r_skid_vld;
  assign w_acc       = in_valid & in_ready;
  assign w_rel       = r_main_vld & out_ready;
  assign w_main_free = ~r_main_vld | w_rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_vld    <= 1'b0;
      r_skid_vld    <= 1'b0;
      r_main_result <= '0;
      r_main_rd     <= '0;
      r_main_wen    <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_vld) begin
        r_main_vld    <= 1'b1;
        r_main_result <= r_skid_result;
        r_main_rd     <= r_skid_rd;
        r_main_wen    <= r_skid_wen;
        r_skid_vld    <= 1'b0;
      end else if (w_acc) begin
        r_main_vld    <= 1'b1;
        r_main_result <= in_result;
        r_main_rd     <= in_rd;
        r_main_wen    <= in_wen;
      end else begin
        r_main_vld    <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid_vld <= 1'b1;
    end
  end

  // Skid payload is only meaningful while r_skid_vld is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_acc && !w_main_free) begin
      r_skid_result <= in_result;
      r_skid_rd     <= in_rd;
      r_skid_wen    <= in_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_zero <= 1'b0;
      r_flag_sign <= 1'b0;
    end else if (w_acc && in_flag_upd) begin
      r_flag_zero <= in_zero;
      r_flag_sign <= in_sign;
    end
  end

  assign out_valid  = r_main_vld;
  assign out_result = r_main_result;
  assign out_rd     = r_main_rd;
  assign out_wen    = r_main_wen;
  assign flag_zero  = r_flag_zero;
  assign flag_sign  = r_flag_sign;
  assign br_taken   = br_eval(br_cond, r_flag_zero, r_flag_sign);
  assign occupancy  = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the result path.
REQ-002 The block SHALL have parameter TAG_W, default 5, giving the width of the destination-register tag.
REQ-003 The block SHALL have one clock and one reset: reset is synchronous and active-high; ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  upstream ALU result valid.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 in_result  input  DATA_W  ALU out word.
REQ-009 in_zero  input  1  ALU zero flag.
REQ-010 in_sign  input  1  ALU sign flag.
REQ-011 in_rd  input  TAG_W  destination register tag.
REQ-012 in_wen  input  1  result is to be written back.
REQ-013 in_flag_upd  input  1  this result updates the flag register.
REQ-014 out_valid  output  1  writeback entry valid.
REQ-015 out_ready  input  1  writeback consumer accepts.
REQ-016 out_result  output  DATA_W  buffered result.
REQ-017 out_rd  output  TAG_W  buffered tag.
REQ-018 out_wen  output  1  buffered write enable.
REQ-019 flag_zero  output  1  registered zero flag.
REQ-020 flag_sign  output  1  registered sign flag.
REQ-021 br_cond  input  3  branch condition select.
REQ-022 br_taken  output  1  condition evaluated on registered flags.
REQ-023 occupancy  output  2  entries held (0..2).

Function
REQ-024 The block SHALL be a 2-entry buffer: main entry drives out_*; skid entry holds the overflow.
REQ-025 Accept SHALL occur when in_valid & in_ready; release SHALL occur when out_valid & out_ready.
REQ-026 in_ready SHALL equal (not rst) and (skid entry empty), with no combinational path from out_ready.
REQ-027 Accept with main empty, or main releasing and skid empty: the entry SHALL load into main next cycle.
REQ-028 Accept with main full and not releasing: the entry SHALL load into skid; in_ready SHALL drop next cycle.
REQ-029 Release with skid full: skid SHALL move to main next cycle; skid becomes empty.
REQ-030 Simultaneous accept and release with occupancy 1 SHALL keep occupancy 1, new entry in main.
REQ-031 Latency SHALL be 1 cycle from accept to out_valid when the buffer is empty; ordering SHALL be strict FIFO.
REQ-032 out_result/out_rd/out_wen SHALL hold stable while out_valid=1 and out_ready=0.
REQ-033 occupancy SHALL equal main_valid + skid_valid.
REQ-034 On accept with in_flag_upd=1, flag_zero/flag_sign SHALL load in_zero/in_sign next cycle; otherwise flags SHALL hold.
REQ-035 Flag update SHALL depend only on accept, not on downstream release.
REQ-036 br_taken SHALL be combinational from flags: 0 never; 1 always; 2 Z; 3 !Z; 4 S; 5 !S; 6 Z|S; 7 !Z&!S.
REQ-037 Entries with in_wen=0 SHALL still flow through the buffer and be presented with out_wen=0.

Reset
REQ-038 On rst=1 at a clock edge: main and skid valid SHALL clear; out_valid=0, occupancy=0, flag_zero=0, flag_sign=0.
REQ-039 out_result, out_rd, out_wen SHALL reset to 0.
REQ-040 While rst=1, in_ready SHALL be 0 and no accept SHALL occur; mid-operation reset SHALL discard all held entries.
REQ-041 br_taken after reset SHALL follow REQ-036 with Z=0, S=0 (e.g. cond 7 -> 1).

Verification
REQ-042 Single pass: accept result 0x0000_0005, rd=3, wen=1, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3; following cycle out_valid=0.
REQ-043 Backpressure: out_ready=0, push 0x11, 0x22 -> occupancy=2, in_ready=0, out_result=0x11 held; raise out_ready -> 0x11 then 0x22 on consecutive cycles, in_ready=1 after first release.
REQ-044 Streaming: in_valid=1 and out_ready=1 every cycle for 8 results 1..8 -> outputs 1..8 in order, occupancy stays 1, no bubbles.
REQ-045 Flags: accept zero=1,sign=0,flag_upd=1 then zero=0,sign=1,flag_upd=0 -> flags Z=1,S=0; br_cond=2 -> br_taken=1, br_cond=7 -> 0.
REQ-046 Reset mid-operation: occupancy=2, flags Z=1,S=1, assert rst one cycle -> out_valid=0, occupancy=0, flags 0, in_ready=1 the cycle after rst deasserts.
